// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall inputs, instruction memory port and the IF/ID outputs.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface instruction_fetch_unit_if;
   logic        do_jump;
   logic [31:0] jump_addr;
   logic        stall;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        fetch_fault;

   modport master (
      input  do_jump, jump_addr, stall, imem_rdata,
      output imem_addr, if_pc, if_instr, if_valid, fetch_fault
   );

   modport slave (
      output do_jump, jump_addr, stall, imem_rdata,
      input  imem_addr, if_pc, if_instr, if_valid, fetch_fault
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem, presents IF/ID to decode.
// Optional misaligned-jump trap (FAULT state) built only when JUMP_ALIGN_CHECK_EN is defined.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input logic                        sys_clk,
   input logic                        rst_n,
   instruction_fetch_unit_if.master   fb
);

   logic [31:0] pc_req;
   logic [31:0] if_pc_q;
   logic [31:0] hold_reg;
   logic        if_valid_q;
   logic        held;
   logic [31:0] jump_tgt;
   logic        jump_bad;
   logic        running;
   logic        fault_out;

   assign jump_tgt = fb.jump_addr & ~32'h0000_0003;

`ifdef JUMP_ALIGN_CHECK_EN
   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;
   state_t state, state_nxt;

   assign jump_bad = fb.do_jump && (fb.jump_addr[1:0] != 2'b00);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == RUN && jump_bad) state_nxt = FAULT;
   end

   always_comb begin
      fault_out = 1'b0;
      running   = 1'b1;
      if (state == FAULT) begin
         fault_out = 1'b1;
         running   = 1'b0;
      end
   end
`else
   assign jump_bad  = 1'b0;
   assign running   = 1'b1;
   assign fault_out = 1'b0;
`endif

   // Fetch request / IF-ID stage boundary
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_req     <= RESET_PC;
         if_pc_q    <= RESET_PC;
         if_valid_q <= 1'b0;
         held       <= 1'b0;
         hold_reg   <= 32'h0;
      end else if (!running) begin
         if_valid_q <= 1'b0;
      end else if (fb.do_jump) begin
         // Squash the in-flight fetch; a trapped jump leaves pc_req untouched.
         if_valid_q <= 1'b0;
         if (!jump_bad) begin
            pc_req <= jump_tgt;
            held   <= 1'b0;
         end
      end else if (fb.stall) begin
         hold_reg <= fb.if_instr;
         held     <= 1'b1;
      end else begin
         if_pc_q    <= pc_req;
         if_valid_q <= 1'b1;
         pc_req     <= pc_req + 32'(PC_STEP);
         held       <= 1'b0;
      end
   end

   // imem keeps reading pc_req during a stall, so rdata is already correct on release.
   assign fb.imem_addr   = pc_req;
   assign fb.if_pc       = if_pc_q;
   assign fb.if_valid    = if_valid_q;
   assign fb.if_instr    = held ? hold_reg : fb.imem_rdata;
   assign fb.fetch_fault = fault_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a fetch-stream reference model.
module tb_instruction_fetch_unit;
   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(.RESET_PC(TB_RESET_PC), .PC_STEP(4)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .fb      (bus)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   always @(posedge sys_clk) bus.imem_rdata <= mem_word(bus.imem_addr);

   // Reference model: the decode-visible stream and the next address to fetch
   logic [31:0] m_next, m_pc;
   logic        m_valid, m_fault;

   task automatic model_reset();
      m_next  = TB_RESET_PC;
      m_pc    = TB_RESET_PC;
      m_valid = 1'b0;
      m_fault = 1'b0;
   endtask

   task automatic model_step(input logic j, input logic [31:0] ja, input logic s);
      logic bad;
      bad = 1'b0;
`ifdef JUMP_ALIGN_CHECK_EN
      bad = (ja % 4) != 0;
`endif
      if (m_fault) begin
         m_valid = 1'b0;
      end else if (j) begin
         m_valid = 1'b0;
         if (bad) m_fault = 1'b1;
         else     m_next  = ja - (ja % 4);
      end else if (!s) begin
         m_pc    = m_next;
         m_valid = 1'b1;
         m_next  = m_next + 32'd4;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_val("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
      check_val("if_pc", bus.if_pc, m_pc);
      check_val("imem_addr", bus.imem_addr, m_next);
      check_val("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, m_fault});
      if (m_valid) check_val("if_instr", bus.if_instr, mem_word(m_pc));
   endtask

   task automatic cycle(input logic j, input logic [31:0] ja, input logic s);
      bus.do_jump   = j;
      bus.jump_addr = ja;
      bus.stall     = s;
      @(posedge sys_clk);
      model_step(j, ja, s);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.do_jump   = 1'b0;
      bus.stall     = 1'b0;
      bus.jump_addr = 32'h0;
      #2;
      model_reset();
      compare_all();
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      compare_all();
      @(negedge sys_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] ja;
      logic        j, s;
      int          fault_cycles;
      bus.do_jump   = 1'b0;
      bus.stall     = 1'b0;
      bus.jump_addr = 32'h0;
      #3;

      // Sequential fetch from reset
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
      check_val("seq_pc3", bus.if_pc, 32'h0000_000C);

      // Jump to 0x100 with pc_req at 0x10
      check_val("pre_jump_req", bus.imem_addr, 32'h0000_0010);
      cycle(1'b1, 32'h0000_0100, 1'b0);
      check_val("jump_bubble", {31'b0, bus.if_valid}, 32'd0);
      cycle(1'b0, 32'h0, 1'b0);
      check_val("jump_tgt", bus.if_pc, 32'h0000_0100);
      cycle(1'b0, 32'h0, 1'b0);

      // Three-cycle stall at if_pc = 0x8
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         check_val("stall_instr", bus.if_instr, mem_word(32'h8));
      end
      cycle(1'b0, 32'h0, 1'b0);
      check_val("stall_release", bus.if_pc, 32'h0000_000C);

      // Jump and stall together
      cycle(1'b1, 32'h0000_0200, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0);
      check_val("jump_stall_tgt", bus.if_pc, 32'h0000_0200);

      // Address wrap
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      check_val("wrap_pc", bus.if_pc, 32'h0000_0000);

      // Misaligned jump
      cycle(1'b1, 32'h0000_0102, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
`ifdef JUMP_ALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_0400, 1'b0);
      check_val("fault_held", {31'b0, bus.fetch_fault}, 32'd1);
      do_reset();
      cycle(1'b0, 32'h0, 1'b0);
      check_val("fault_restart", bus.if_pc, TB_RESET_PC);
`else
      check_val("misalign_clear", bus.if_pc, 32'h0000_0100);
`endif

      // Randomized traffic with occasional resets
      fault_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0 || fault_cycles > 8) begin
            do_reset();
            fault_cycles = 0;
         end
         j  = ($urandom_range(0, 7) == 0);
         s  = ($urandom_range(0, 3) == 0);
         ja = $urandom;
         if ($urandom_range(0, 5) != 0) ja[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
         cycle(j, ja, s);
         if (m_fault) fault_cycles++;
      end

      // Asynchronous reset in the middle of a stall
      cycle(1'b0, 32'h0, 1'b1);
      do_reset();
      cycle(1'b0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Instruction fetch stage. Sits directly downstream of the negedge-registered jump/stall pipeline register. Consumes its do_jump/jump_addr/stall outputs, owns the program counter, and drives a synchronous instruction memory (1-cycle read latency). Produces an IF/ID bundle (pc, instr, valid) for decode, with stall hold and jump squash.

Parameters:
RESET_PC, 32'h0000_0000, fetch address issued out of reset (word aligned)
PC_STEP, 4, sequential increment in bytes

Ports:
sys_clk  input  1  clock; all state updates on posedge
rst_n  input  1  reset
do_jump  input  1  redirect request, from upstream negedge register
jump_addr  input  32  redirect target
stall  input  1  hold fetch and IF/ID outputs
imem_addr  output  32  address to sync instruction memory (= pc_req register)
imem_rdata  input  32  memory data; corresponds to imem_addr of previous cycle
if_pc  output  32  PC of instruction presented to decode
if_instr  output  32  instruction presented to decode
if_valid  output  1  if_pc/if_instr hold a real instruction
fetch_fault  output  1  misaligned jump trap (see Optional Feature)

Behaviour:
- Reset: rst_n, asynchronous, active-low. On reset: pc_req=RESET_PC, if_pc=RESET_PC, if_valid=0, held=0, hold_reg=0, fetch_fault=0, state=RUN.
- Internal registers: pc_req (address in flight), if_pc, if_valid, held flag, hold_reg[31:0], state {RUN, FAULT}.
- if_instr = held ? hold_reg : imem_rdata (combinational mux). No other combinational paths from inputs to outputs.
- RUN, each posedge, priority do_jump > stall > advance:
  - do_jump=1: pc_req<=jump_addr with bits [1:0] forced to 0; if_valid<=0 (squash in-flight fetch); held<=0. This applies even while stall=1.
  - stall=1, do_jump=0: pc_req, if_pc, if_valid unchanged; hold_reg<=if_instr; held<=1. Multi-cycle stall keeps hold_reg stable.
  - otherwise: if_pc<=pc_req; if_valid<=1; pc_req<=pc_req+PC_STEP, mod 2^32, so 0xFFFF_FFFC wraps to 0; held<=0.
- Latency: reset release to first if_valid=1 is 1 posedge. A jump costs exactly 1 bubble cycle: at the edge after the jump, if_valid=0. At the next non-stalled edge, if_pc=target and if_valid=1.
- Stall release: imem_addr stays at pc_req during the stall, so imem_rdata on the release cycle already holds the correct next instruction. No refetch.
- Stall while if_valid=0: bubble persists; hold_reg content is don't-care.
- Reset mid-stall or mid-jump: everything returns to reset values immediately; pending jump is lost.
- FAULT state: exists only with the optional feature.

Optional Feature:
Macro JUMP_ALIGN_CHECK_EN.
- Defined: in RUN, a do_jump with jump_addr[1:0]!=0 enters FAULT instead of redirecting. In FAULT: fetch_fault=1, if_valid=0, pc_req/if_pc frozen at pre-jump values, and all inputs are ignored until reset.
- Not defined: low bits are silently cleared, fetch_fault is tied 0, and no FAULT state is built.

Test Plan:
- Reset release, no stall/jump, RESET_PC=0, memory returns data=addr -> if_pc/if_instr sequence 0,4,8,C from cycle 1; if_valid=1 from cycle 1.
- Jump to 0x100 when pc_req=0x10 -> one cycle if_valid=0, then if_pc=0x100, 0x104; no 0x10 instruction is ever valid.
- Stall 3 cycles while if_pc=0x8 -> if_pc=0x8, if_instr=instr(0x8) held stable all 3 cycles; after release if_pc=0xC with correct instr.
- Jump and stall asserted the same cycle, target 0x200 -> jump taken, bubble, then if_pc=0x200 once stall drops.
- pc_req=0xFFFF_FFFC advancing -> next if_pc=0xFFFF_FFFC, then 0x0000_0000.
- With JUMP_ALIGN_CHECK_EN, jump to 0x102 -> fetch_fault=1, if_valid=0 until rst_n pulse, then if_pc restarts at RESET_PC. Without the macro, the same jump fetches 0x100.
